// File: rtl/codificador_de_teclas_da_senha.sv
// Push-button encoder: synchronises and debounces four raw keys and emits one
// single-cycle one-hot code per accepted press, with full-release re-arming.
module codificador_de_teclas_da_senha #(
    parameter int unsigned TEMPO_DEBOUNCE = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_botoes,
    output logic [3:0] o_senha_inserida,
    output logic       o_codigo_valido,
    output logic       o_tecla_invalida,
    output logic       o_ocupado,
    output logic [2:0] o_contagem_de_digitos
);

    localparam int unsigned CW = $clog2(TEMPO_DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TEMPO_DEBOUNCE - 1);

    localparam logic [2:0] OCIOSO             = 3'd0;
    localparam logic [2:0] FILTRANDO_PRESSAO  = 3'd1;
    localparam logic [2:0] EMITINDO           = 3'd2;
    localparam logic [2:0] AGUARDANDO_SOLTURA = 3'd3;
    localparam logic [2:0] FILTRANDO_SOLTURA  = 3'd4;

    logic [3:0]    r_sync1;
    logic [3:0]    r_amostra;
    logic [3:0]    r_tecla;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_estado;
    logic [3:0]    r_senha;
    logic          r_valido;
    logic          r_invalida;
    logic [2:0]    r_contagem;

    logic [2:0]    w_estado;
    logic [3:0]    w_tecla;
    logic [CW-1:0] w_cnt;
    logic          w_entra_emit;
    logic          w_um_bit;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_um_bit = (r_tecla != 4'b0000) && ((r_tecla & (r_tecla - 4'd1)) == 4'b0000);

    always_comb begin
        w_estado = r_estado;
        w_tecla  = r_tecla;
        w_cnt    = r_cnt;
        case (r_estado)
            OCIOSO: begin
                if (r_amostra != 4'b0000) begin
                    w_tecla  = r_amostra;
                    w_cnt    = '0;
                    w_estado = FILTRANDO_PRESSAO;
                end
            end
            FILTRANDO_PRESSAO: begin
                if (r_amostra == 4'b0000) begin
                    w_estado = OCIOSO;
                end else if (r_amostra != r_tecla) begin
                    w_tecla = r_amostra;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_estado = EMITINDO;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            EMITINDO: w_estado = AGUARDANDO_SOLTURA;
            AGUARDANDO_SOLTURA: begin
                if (r_amostra == 4'b0000) begin
                    w_cnt    = '0;
                    w_estado = FILTRANDO_SOLTURA;
                end
            end
            FILTRANDO_SOLTURA: begin
                if (r_amostra != 4'b0000) begin
                    w_estado = AGUARDANDO_SOLTURA;
                end else if (r_cnt == CNT_MAX) begin
                    w_estado = OCIOSO;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: w_estado = OCIOSO;
        endcase
    end

    // Output registers load on the edge entering EMITINDO, so they are high
    // exactly while the state register holds EMITINDO.
    assign w_entra_emit = (r_estado == FILTRANDO_PRESSAO) && (w_estado == EMITINDO);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= 4'b0000;
            r_amostra  <= 4'b0000;
            r_tecla    <= 4'b0000;
            r_cnt      <= '0;
            r_estado   <= OCIOSO;
            r_senha    <= 4'b0000;
            r_valido   <= 1'b0;
            r_invalida <= 1'b0;
            r_contagem <= 3'd0;
        end else begin
            r_sync1    <= i_botoes;
            r_amostra  <= r_sync1;
            r_tecla    <= w_tecla;
            r_cnt      <= w_cnt;
            r_estado   <= w_estado;
            r_senha    <= (w_entra_emit && w_um_bit) ? r_tecla : 4'b0000;
            r_valido   <= w_entra_emit && w_um_bit;
            r_invalida <= w_entra_emit && !w_um_bit;
            if (w_entra_emit && w_um_bit && (r_contagem != 3'd7)) begin
                r_contagem <= r_contagem + 3'd1;
            end
        end
    end

    assign o_senha_inserida      = r_senha;
    assign o_codigo_valido       = r_valido;
    assign o_tecla_invalida      = r_invalida;
    assign o_ocupado             = (r_estado != OCIOSO);
    assign o_contagem_de_digitos = r_contagem;

endmodule

// File: tb/tb_codificador_de_teclas_da_senha.sv
// Directed bench for the key encoder: default debounce instance plus a
// TEMPO_DEBOUNCE=1 instance sharing the same stimulus.
module tb_codificador_de_teclas_da_senha;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bot;

    logic [3:0] senha, senha1;
    logic       valido, valido1, invalida, invalida1, ocupado, ocupado1;
    logic [2:0] cont, cont1;

    int checks = 0;
    int errors = 0;

    int edge_no, n_valid, n_inval, first_valid, first_inval, fall_edge;
    int n_valid1, first_valid1, fall_edge1;
    int bad = 0;
    logic [3:0] code;
    logic [3:0] key;
    logic prev_ocup = 1'b0;
    logic prev_ocup1 = 1'b0;

    always #5 clk = ~clk;

    codificador_de_teclas_da_senha #(.TEMPO_DEBOUNCE(16)) dut (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_botoes              (bot),
        .o_senha_inserida      (senha),
        .o_codigo_valido       (valido),
        .o_tecla_invalida      (invalida),
        .o_ocupado             (ocupado),
        .o_contagem_de_digitos (cont)
    );

    codificador_de_teclas_da_senha #(.TEMPO_DEBOUNCE(1)) dut1 (
        .i_clk                 (clk),
        .i_reset               (rst),
        .i_botoes              (bot),
        .o_senha_inserida      (senha1),
        .o_codigo_valido       (valido1),
        .o_tecla_invalida      (invalida1),
        .o_ocupado             (ocupado1),
        .o_contagem_de_digitos (cont1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        edge_no      = 0;
        n_valid      = 0;
        n_inval      = 0;
        first_valid  = -1;
        first_inval  = -1;
        fall_edge    = -1;
        n_valid1     = 0;
        first_valid1 = -1;
        fall_edge1   = -1;
        code         = 4'b0000;
    endtask

    // Advance n edges, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (valido === 1'b1) begin
                n_valid++;
                if (first_valid < 0) begin
                    first_valid = edge_no;
                    code        = senha;
                end
            end
            if (invalida === 1'b1) begin
                n_inval++;
                if (first_inval < 0) first_inval = edge_no;
            end
            if (valido !== (senha != 4'b0000)) bad++;
            if (valido === 1'b1 && invalida === 1'b1) bad++;
            if (prev_ocup === 1'b1 && ocupado === 1'b0 && fall_edge < 0) fall_edge = edge_no;
            prev_ocup = ocupado;
            if (valido1 === 1'b1) begin
                n_valid1++;
                if (first_valid1 < 0) first_valid1 = edge_no;
            end
            if (prev_ocup1 === 1'b1 && ocupado1 === 1'b0 && fall_edge1 < 0) fall_edge1 = edge_no;
            prev_ocup1 = ocupado1;
        end
    endtask

    initial begin
        // Reset state
        clear_mon();
        rst = 1'b1;
        bot = 4'b0000;
        run(3);
        check("rst_senha", senha, 4'b0000);
        check("rst_valido", valido, 1'b0);
        check("rst_invalida", invalida, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_cont", cont, 3'd0);
        rst = 1'b0;

        // Clean press of key 1, held 40 cycles
        clear_mon();
        bot = 4'b0001;
        run(40);
        check("t1_n_valid", n_valid, 1);
        check("t1_edge", first_valid, 19);
        check("t1_code", code, 4'b0001);
        check("t1_cont", cont, 3'd1);
        check("t1_ocupado_held", ocupado, 1'b1);
        check("t1_d1_edge", first_valid1, 4);
        check("t1_d1_n_valid", n_valid1, 1);
        clear_mon();
        bot = 4'b0000;
        run(40);
        check("t1_fall_edge", fall_edge, 19);
        check("t1_d1_fall_edge", fall_edge1, 4);
        check("t1_rel_no_pulse", n_valid, 0);

        // Bouncing key 2, then stable
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            bot = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            run(3);
        end
        check("t2_bounce_no_pulse", n_valid, 0);
        clear_mon();
        bot = 4'b0010;
        run(30);
        check("t2_n_valid", n_valid, 1);
        check("t2_edge", first_valid, 19);
        check("t2_code", code, 4'b0010);
        check("t2_cont", cont, 3'd2);
        bot = 4'b0000;
        run(40);

        // Lone 5-cycle glitch
        clear_mon();
        bot = 4'b0100;
        run(5);
        bot = 4'b0000;
        run(30);
        check("t2g_n_valid", n_valid, 0);
        check("t2g_n_inval", n_inval, 0);
        check("t2g_ocupado", ocupado, 1'b0);

        // Multi-key pattern
        clear_mon();
        bot = 4'b0101;
        run(30);
        check("t3_n_inval", n_inval, 1);
        check("t3_inval_edge", first_inval, 19);
        check("t3_n_valid", n_valid, 0);
        check("t3_cont", cont, 3'd2);
        bot = 4'b0000;
        run(40);

        // Four-key sequence after a fresh reset
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        check("t4_cont_rst", cont, 3'd0);
        for (int k = 0; k < 4; k++) begin
            key = 4'b0001 << k;
            clear_mon();
            bot = key;
            run(25);
            check("t4_code", code, key);
            check("t4_n_valid", n_valid, 1);
            bot = 4'b0000;
            run(25);
        end
        check("t4_cont", cont, 3'd4);

        // Key 4 held long, key 1 added mid-hold
        clear_mon();
        bot = 4'b1000;
        run(100);
        bot = 4'b1001;
        run(100);
        bot = 4'b0000;
        run(40);
        check("t5_n_valid", n_valid, 1);
        check("t5_code", code, 4'b1000);
        check("t5_n_inval", n_inval, 0);
        check("t5_cont", cont, 3'd5);

        // Nine more presses saturate the digit counter
        clear_mon();
        for (int p = 0; p < 9; p++) begin
            bot = 4'b0001;
            run(25);
            bot = 4'b0000;
            run(25);
        end
        check("t5_sat_n_valid", n_valid, 9);
        check("t5_sat_cont", cont, 3'd7);

        // Reset mid-press with the key still held (debounce counter at 8)
        clear_mon();
        bot = 4'b0010;
        run(11);
        rst = 1'b1;
        run(1);
        check("t6_rst_senha", senha, 4'b0000);
        check("t6_rst_valido", valido, 1'b0);
        check("t6_rst_invalida", invalida, 1'b0);
        check("t6_rst_ocupado", ocupado, 1'b0);
        check("t6_rst_cont", cont, 3'd0);
        run(1);
        check("t6_no_pulse", n_valid, 0);
        rst = 1'b0;
        clear_mon();
        run(30);
        check("t6_edge", first_valid, 19);
        check("t6_n_valid", n_valid, 1);
        check("t6_code", code, 4'b0010);
        check("t6_cont", cont, 3'd1);

        check("output_consistency", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
